param_mem_server: RTL and testbench

- Responder side of the classifier's memory-read interface.
- Receives a framed byte stream from the UART receive path and writes weights, biases and image pixels into local storage.
- Serves zero-latency reads to the inference engine and pulses start_inference once a complete image has been stored.
- Sits between the UART receiver and the inference engine; it is the only writer of the model and image memories.

---
 rtl/param_mem_server.sv | 214 +++++++++++++++++++++
 tb/tb_param_mem_server.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/param_mem_server.sv
// param_mem_server
// ----------------
// Responder side of the classifier memory-read interface. Parses a framed
// byte stream from the UART receiver and stores model weights, biases and
// image pixels; serves zero-latency reads to the inference engine and
// pulses start_inference once a complete image is stored (only when a
// complete model is present).
//
// Frames:
//   HDR_MODEL, NUM_CLASSES*NUM_PIXELS weight bytes, 4*NUM_CLASSES bias bytes
//   (little-endian 32-bit words).
//   HDR_IMAGE, NUM_PIXELS pixel bytes.
//
// Optional feature (macro PARAM_MEM_CHECKSUM_EN): every frame carries one
// trailing XOR-of-payload byte. A mismatch sets the sticky frame_error
// (cleared by the next accepted header) and suppresses weights_ready or the
// start pulse. Without the macro there is no trailer and frame_error is 0.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rx_valid, rx_data     received byte strobe and value
//   weight_addr/_data     weight read port (class*NUM_PIXELS+pixel)
//   bias_addr/bias_data   bias read port
//   input_addr/pixel      pixel read port
//   infer_busy            engine busy; headers are dropped while high
//   weights_ready         complete model stored
//   start_inference       one-cycle start pulse
//   load_active           a frame is being received
//   frame_error           sticky checksum error
module param_mem_server #(
    parameter int          NUM_CLASSES = 10,
    parameter int          NUM_PIXELS  = 784,
    parameter logic [7:0]  HDR_MODEL   = 8'hA5,
    parameter logic [7:0]  HDR_IMAGE   = 8'h5A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic [12:0] weight_addr,
    output logic [7:0]  weight_data,
    input  logic [3:0]  bias_addr,
    output logic [31:0] bias_data,
    input  logic [9:0]  input_addr,
    output logic [7:0]  input_pixel,
    input  logic        infer_busy,
    output logic        weights_ready,
    output logic        start_inference,
    output logic        load_active,
    output logic        frame_error
);

    localparam logic [12:0] W_TOTAL = 13'(NUM_CLASSES * NUM_PIXELS);
    localparam logic [12:0] W_LAST  = 13'(NUM_CLASSES * NUM_PIXELS - 1);
    localparam logic [12:0] B_LAST  = 13'(4 * NUM_CLASSES - 1);
    localparam logic [12:0] P_LAST  = 13'(NUM_PIXELS - 1);
    localparam logic [3:0]  B_TOTAL = 4'(NUM_CLASSES);
    localparam logic [9:0]  P_TOTAL = 10'(NUM_PIXELS);

    typedef enum logic [2:0] {
        S_HDR, S_LOAD_W, S_LOAD_B, S_LOAD_IMG, S_CHECK, S_START
    } state_t;

    state_t      state_reg, state_next;
    logic [12:0] counter_reg;
    logic [23:0] asm_reg;           // first three bias bytes of the current word
    logic        weights_ready_reg;
    logic        start_reg, start_next;

    logic [7:0]  weight_mem [0:NUM_CLASSES*NUM_PIXELS-1];
    logic [7:0]  pixel_mem  [0:NUM_PIXELS-1];
    logic [NUM_CLASSES-1:0][31:0] bias_q;

    logic hdr_model_ok, hdr_image_ok;
    logic w_last, b_last, p_last;
    logic bias_wr;

    assign hdr_model_ok = (state_reg == S_HDR) && rx_valid && !infer_busy && (rx_data == HDR_MODEL);
    assign hdr_image_ok = (state_reg == S_HDR) && rx_valid && !infer_busy && (rx_data == HDR_IMAGE);
    assign w_last  = (counter_reg == W_LAST);
    assign b_last  = (counter_reg == B_LAST);
    assign p_last  = (counter_reg == P_LAST);
    assign bias_wr = (state_reg == S_LOAD_B) && rx_valid && (counter_reg[1:0] == 2'd3);

`ifdef PARAM_MEM_CHECKSUM_EN
    logic [7:0] csum_reg;
    logic       is_model_reg;
    logic       frame_error_reg;
    logic       csum_match;
    assign csum_match  = (rx_data == csum_reg);
    assign frame_error = frame_error_reg;
`else
    assign frame_error = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_HDR;
        else        state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_HDR: begin
                if (hdr_model_ok)      state_next = S_LOAD_W;
                else if (hdr_image_ok) state_next = S_LOAD_IMG;
            end
            S_LOAD_W:   if (rx_valid && w_last) state_next = S_LOAD_B;
`ifdef PARAM_MEM_CHECKSUM_EN
            S_LOAD_B:   if (rx_valid && b_last) state_next = S_CHECK;
            S_LOAD_IMG: if (rx_valid && p_last) state_next = S_CHECK;
            S_CHECK:    if (rx_valid) state_next = (!is_model_reg && csum_match) ? S_START : S_HDR;
`else
            S_LOAD_B:   if (rx_valid && b_last) state_next = S_HDR;
            S_LOAD_IMG: if (rx_valid && p_last) state_next = S_START;
`endif
            S_START:    state_next = S_HDR;
            default:    state_next = S_HDR;
        endcase
    end

    // Output decode
    always_comb begin
        load_active = 1'b0;
        start_next  = 1'b0;
        case (state_reg)
            S_LOAD_W, S_LOAD_B, S_LOAD_IMG, S_CHECK: load_active = 1'b1;
            S_START: start_next = weights_ready_reg;
            default: ;
        endcase
    end

    // Frame datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_reg       <= '0;
            asm_reg           <= '0;
            weights_ready_reg <= 1'b0;
            start_reg         <= 1'b0;
`ifdef PARAM_MEM_CHECKSUM_EN
            csum_reg          <= '0;
            is_model_reg      <= 1'b0;
            frame_error_reg   <= 1'b0;
`endif
        end else begin
            start_reg <= start_next;
            if (hdr_model_ok || hdr_image_ok) begin
                counter_reg <= '0;
            end else if (rx_valid && (state_reg == S_LOAD_W || state_reg == S_LOAD_B
                                      || state_reg == S_LOAD_IMG)) begin
                // The last byte of each section rewinds the counter for the next one.
                if ((state_reg == S_LOAD_W && w_last) || (state_reg == S_LOAD_B && b_last)
                    || (state_reg == S_LOAD_IMG && p_last))
                    counter_reg <= '0;
                else
                    counter_reg <= counter_reg + 13'd1;
            end
            if (state_reg == S_LOAD_B && rx_valid)
                asm_reg <= {rx_data, asm_reg[23:8]};
            if (hdr_model_ok)
                weights_ready_reg <= 1'b0;
`ifdef PARAM_MEM_CHECKSUM_EN
            if (hdr_model_ok || hdr_image_ok) begin
                csum_reg        <= '0;
                frame_error_reg <= 1'b0;
                is_model_reg    <= hdr_model_ok;
            end else if (rx_valid && (state_reg == S_LOAD_W || state_reg == S_LOAD_B
                                      || state_reg == S_LOAD_IMG)) begin
                csum_reg <= csum_reg ^ rx_data;
            end
            if (state_reg == S_CHECK && rx_valid) begin
                if (!csum_match)       frame_error_reg   <= 1'b1;
                else if (is_model_reg) weights_ready_reg <= 1'b1;
            end
`else
            if (state_reg == S_LOAD_B && rx_valid && b_last)
                weights_ready_reg <= 1'b1;
`endif
        end
    end

    assign weights_ready   = weights_ready_reg;
    assign start_inference = start_reg;

    // Storage: contents survive reset, so these have no reset branch.
    always_ff @(posedge clk) begin
        if (state_reg == S_LOAD_W && rx_valid)
            weight_mem[counter_reg] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (state_reg == S_LOAD_IMG && rx_valid)
            pixel_mem[counter_reg[9:0]] <= rx_data;
    end

    generate
        for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_bias
            logic [31:0] entry_reg;
            always_ff @(posedge clk) begin
                if (bias_wr && (counter_reg[5:2] == 4'(gi)))
                    entry_reg <= {rx_data, asm_reg};
            end
            assign bias_q[gi] = entry_reg;
        end
    endgenerate

    // Zero-latency reads; out-of-range addresses read as 0.
    assign weight_data = (weight_addr < W_TOTAL) ? weight_mem[weight_addr] : 8'h00;
    assign bias_data   = (bias_addr < B_TOTAL)   ? bias_q[bias_addr]       : 32'h0;
    assign input_pixel = (input_addr < P_TOTAL)  ? pixel_mem[input_addr]   : 8'h00;

endmodule

// File: tb/tb_param_mem_server.sv
module tb_param_mem_server;

    localparam int NW = 7840;
    localparam int NB = 10;
    localparam int NP = 784;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [12:0] weight_addr;
    logic [7:0]  weight_data;
    logic [3:0]  bias_addr;
    logic [31:0] bias_data;
    logic [9:0]  input_addr;
    logic [7:0]  input_pixel;
    logic        infer_busy;
    logic        weights_ready;
    logic        start_inference;
    logic        load_active;
    logic        frame_error;

    always #5 clk = ~clk;

    param_mem_server dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .weight_addr(weight_addr), .weight_data(weight_data),
        .bias_addr(bias_addr), .bias_data(bias_data),
        .input_addr(input_addr), .input_pixel(input_pixel),
        .infer_busy(infer_busy), .weights_ready(weights_ready),
        .start_inference(start_inference), .load_active(load_active),
        .frame_error(frame_error)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: memory images plus the expected status outputs.
    logic [7:0]  wm [NW];
    bit          wk [NW];
    logic [31:0] bm [NB];
    bit          bk [NB];
    logic [7:0]  pm [NP];
    bit          pk [NP];
    logic exp_wr = 1'b0, exp_la = 1'b0, exp_start = 1'b0, exp_fe = 1'b0;

    bit          lit_mode = 1'b0;
    logic [12:0] lit_w = '0;
    logic [3:0]  lit_b = '0;
    logic [9:0]  lit_p = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Compare process: drives the read addresses and checks every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (lit_mode) begin
                weight_addr = lit_w; bias_addr = lit_b; input_addr = lit_p;
            end else begin
                weight_addr = 13'($urandom_range(0, 8191));
                bias_addr   = 4'($urandom_range(0, 15));
                input_addr  = 10'($urandom_range(0, 1023));
            end
            #1;
            chk("weights_ready", {31'b0, weights_ready}, {31'b0, exp_wr});
            chk("load_active", {31'b0, load_active}, {31'b0, exp_la});
            chk("start_inference", {31'b0, start_inference}, {31'b0, exp_start});
            chk("frame_error", {31'b0, frame_error}, {31'b0, exp_fe});
            if (int'(weight_addr) >= NW) chk("weight_oor", {24'b0, weight_data}, 32'h0);
            else if (wk[weight_addr])    chk("weight_rd", {24'b0, weight_data}, {24'b0, wm[weight_addr]});
            if (int'(bias_addr) >= NB)   chk("bias_oor", bias_data, 32'h0);
            else if (bk[bias_addr])      chk("bias_rd", bias_data, bm[bias_addr]);
            if (int'(input_addr) >= NP)  chk("pixel_oor", {24'b0, input_pixel}, 32'h0);
            else if (pk[input_addr])     chk("pixel_rd", {24'b0, input_pixel}, {24'b0, pm[input_addr]});
        end
    end

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_wr = 1'b0; exp_la = 1'b0; exp_start = 1'b0; exp_fe = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Model frame; weights i[7:0] (inv=0) or ~i[7:0] (inv=1), biases 0x10000*c+c.
    // abort_at > 0 resets the DUT after that many frame bytes (header included).
    task automatic model_frame(input bit inv, input int abort_at, input bit bad_cs);
        logic [7:0]  cs = 8'h00;
        logic [7:0]  b;
        logic [31:0] v;
        int n;
        send(8'hA5);
        n = 1;
        exp_wr = 1'b0; exp_la = 1'b1; exp_fe = 1'b0;
        for (int i = 0; i < NW; i++) begin
            b = inv ? ~8'(i) : 8'(i);
            send(b);
            wm[i] = b; wk[i] = 1'b1; cs ^= b; n++;
            if (n == abort_at) begin
                do_reset();
                return;
            end
        end
        for (int c = 0; c < NB; c++) begin
            v = 32'h00010000 * c + c;
            for (int k = 0; k < 4; k++) begin
                b = v[8*k +: 8];
                send(b);
                cs ^= b;
            end
            bm[c] = v; bk[c] = 1'b1;
        end
`ifdef PARAM_MEM_CHECKSUM_EN
        send(bad_cs ? ~cs : cs);
        if (bad_cs) exp_fe = 1'b1;
        else        exp_wr = 1'b1;
        exp_la = 1'b0;
`else
        exp_wr = 1'b1;
        exp_la = 1'b0;
`endif
    endtask

    // Image frame; pixels j[7:0] (plain=1) or j[7:0]^0x55 (plain=0).
    // drop_after sends a header byte in the START cycle, which must be ignored.
    task automatic image_frame(input bit plain, input bit drop_after, input bit bad_cs);
        logic [7:0] cs = 8'h00;
        logic [7:0] b;
        bit go;
        send(8'h5A);
        exp_la = 1'b1; exp_fe = 1'b0;
        for (int j = 0; j < NP; j++) begin
            b = plain ? 8'(j) : (8'(j) ^ 8'h55);
            send(b);
            pm[j] = b; pk[j] = 1'b1; cs ^= b;
        end
`ifdef PARAM_MEM_CHECKSUM_EN
        send(bad_cs ? (cs ^ 8'h01) : cs);
        go = !bad_cs;
        if (bad_cs) exp_fe = 1'b1;
`else
        go = 1'b1;
`endif
        exp_la = 1'b0;
        if (go) begin
            if (drop_after) send(8'h5A);
            else begin @(posedge clk); #1; end
            exp_start = exp_wr;
            @(posedge clk);
            #1;
            exp_start = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; infer_busy = 1'b0;
        weight_addr = '0; bias_addr = '0; input_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Image with no model since reset: stored, no start pulse.
        image_frame(1'b0, 1'b0, 1'b0);

        // Header while engine busy: dropped along with what follows.
        infer_busy = 1'b1;
        send(8'h5A);
        send(8'h11);
        send(8'hA5);
        send(8'h22);
        infer_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Model interrupted by reset at frame byte 5000, then a full model.
        model_frame(1'b1, 5000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        model_frame(1'b0, -1, 1'b0);

        lit_mode = 1'b1; lit_w = 13'd300; lit_b = 4'd3; lit_p = 10'd783;
        @(negedge clk); #2;
        chk("lit_weight300", {24'b0, weight_data}, 32'h0000002C);
        chk("lit_bias3", bias_data, 32'h00030003);
        lit_w = 13'd7840; lit_b = 4'd10; lit_p = 10'd784;
        @(negedge clk); #2;
        chk("lit_weight_oor", {24'b0, weight_data}, 32'h0);
        chk("lit_bias_oor", bias_data, 32'h0);
        chk("lit_pixel_oor", {24'b0, input_pixel}, 32'h0);
        lit_mode = 1'b0;

        // Image with model present: start pulse; header during START dropped.
        image_frame(1'b1, 1'b1, 1'b0);
        lit_mode = 1'b1; lit_p = 10'd783; lit_w = 13'd7839; lit_b = 4'd9;
        @(negedge clk); #2;
        chk("lit_pixel783", {24'b0, input_pixel}, 32'h0000000F);
        chk("lit_weight7839", {24'b0, weight_data}, 32'h0000009F);
        chk("lit_bias9", bias_data, 32'h00090009);
        lit_mode = 1'b0;

`ifdef PARAM_MEM_CHECKSUM_EN
        image_frame(1'b0, 1'b0, 1'b1);
        image_frame(1'b1, 1'b0, 1'b0);
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
